// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned PTR_W  = 8;

  localparam logic [ADDR_W-1:0] CSTK_BASE_DEFAULT = 16'hFF00;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  typedef enum logic {
    GNT_PIPE = 1'b0,
    GNT_CS   = 1'b1
  } gnt_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory req/ack bus between the access controller and the memory unit.
interface mem_access_ctrl_if;
  import mem_ctrl_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the side not granted last.
module rr_arbiter_2
  import mem_ctrl_pkg::*;
(
  input  logic pipe_req,
  input  logic cs_req,
  input  gnt_e last_grant,
  output gnt_e gnt_c
);

  always_comb begin
    gnt_c = GNT_PIPE;
    if (pipe_req && cs_req) begin
      gnt_c = (last_grant == GNT_PIPE) ? GNT_CS : GNT_PIPE;
    end else if (cs_req) begin
      gnt_c = GNT_CS;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the data-memory bus between the MEM stage and the call-stack unit,
// one access in flight, with stall, completion pulses and a sticky timeout error.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 64,
  parameter logic [ADDR_W-1:0] CSTK_BASE      = CSTK_BASE_DEFAULT
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              pipe_req,
  input  logic              pipe_we,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_done,
  output logic              pipe_stall,
  input  logic              cs_req,
  input  logic              cs_we,
  input  logic [PTR_W-1:0]  cs_ptr,
  input  logic [DATA_W-1:0] cs_wdata,
  output logic              cs_done,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_err,
  mem_access_ctrl_if.master bus
);

  localparam int unsigned       CNT_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  gnt_e              grant_q, grant_d;
  gnt_e              last_grant_q, last_grant_d;
  gnt_e              arb_gnt;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              pipe_done_q, pipe_done_d;
  logic              cs_done_q, cs_done_d;
  logic              bus_err_q, bus_err_d;
  logic [ADDR_W-1:0] cs_addr;

  assign cs_addr = CSTK_BASE | {{(ADDR_W-PTR_W){1'b0}}, cs_ptr};

  rr_arbiter_2 u_arb (
    .pipe_req   (pipe_req),
    .cs_req     (cs_req),
    .last_grant (last_grant_q),
    .gnt_c      (arb_gnt)
  );

  // Next-state: arbitrate in IDLE (not in a done cycle), hold the bus in WAIT until ack or timeout.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    pipe_done_d  = 1'b0;
    cs_done_d    = 1'b0;
    bus_err_d    = bus_err_q;

    unique case (state_q)
      ST_IDLE: begin
        mem_req_d = 1'b0;
        cnt_d     = '0;
        if ((pipe_req || cs_req) && !(pipe_done_q || cs_done_q)) begin
          grant_d   = arb_gnt;
          mem_req_d = 1'b1;
          state_d   = ST_WAIT;
          if (arb_gnt == GNT_PIPE) begin
            mem_we_d    = pipe_we;
            mem_addr_d  = pipe_addr;
            mem_wdata_d = pipe_wdata;
          end else begin
            mem_we_d    = cs_we;
            mem_addr_d  = cs_addr;
            mem_wdata_d = cs_wdata;
          end
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack) begin
          if (!mem_we_q) rdata_d = bus.mem_rdata;
          pipe_done_d  = (grant_q == GNT_PIPE) && pipe_req;
          cs_done_d    = (grant_q == GNT_CS) && cs_req;
          mem_req_d    = 1'b0;
          last_grant_d = grant_q;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Abort with a poison value so the waiting requester is released.
          rdata_d     = {DATA_W{1'b1}};
          pipe_done_d = (grant_q == GNT_PIPE) && pipe_req;
          cs_done_d   = (grant_q == GNT_CS) && cs_req;
          bus_err_d   = 1'b1;
          mem_req_d   = 1'b0;
          cnt_d       = '0;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_PIPE;
      last_grant_q <= GNT_CS;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      pipe_done_q  <= 1'b0;
      cs_done_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      pipe_done_q  <= pipe_done_d;
      cs_done_q    <= cs_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign pipe_done     = pipe_done_q;
  assign cs_done       = cs_done_q;
  assign rdata         = rdata_q;
  assign bus_err       = bus_err_q;
  assign pipe_stall    = pipe_req & ~pipe_done_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: reset, load, tie arbitration, timeout, back-to-back, abort.
module tb_mem_access_ctrl;

  logic        clock = 1'b0;
  logic        nreset;
  logic        pipe_req, pipe_we;
  logic [15:0] pipe_addr;
  logic [11:0] pipe_wdata;
  logic        pipe_done, pipe_stall;
  logic        cs_req, cs_we;
  logic [7:0]  cs_ptr;
  logic [11:0] cs_wdata;
  logic        cs_done;
  logic [11:0] rdata;
  logic        bus_err;

  int n_chk = 0;
  int n_bad = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl #(.TIMEOUT_CYCLES(64), .CSTK_BASE(16'hFF00)) dut (
    .clock      (clock),
    .nreset     (nreset),
    .pipe_req   (pipe_req),
    .pipe_we    (pipe_we),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_done  (pipe_done),
    .pipe_stall (pipe_stall),
    .cs_req     (cs_req),
    .cs_we      (cs_we),
    .cs_ptr     (cs_ptr),
    .cs_wdata   (cs_wdata),
    .cs_done    (cs_done),
    .rdata      (rdata),
    .bus_err    (bus_err),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_req      = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
    cs_req        = 1'b0; cs_we   = 1'b0; cs_ptr    = '0; cs_wdata   = '0;
    bus.mem_ack   = 1'b0; bus.mem_rdata = '0;
  endtask

  int cnt;
  int ndone;
  int last_done;
  logic [11:0] exp_rd;

  initial begin
    // 1. reset with random inputs
    nreset = 1'b0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      pipe_req    = 1'($urandom); pipe_we = 1'($urandom); pipe_addr = 16'($urandom);
      cs_req      = 1'($urandom); cs_we   = 1'($urandom); cs_ptr    = 8'($urandom);
      bus.mem_ack = 1'($urandom); bus.mem_rdata = 12'($urandom);
      tick();
    end
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_dones", 32'({pipe_done, cs_done}), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_stall", 32'(pipe_stall), 32'(pipe_req));
    idle_inputs();
    nreset = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_no_req", 32'(bus.mem_req), 0);

    // 2. pipe load, three wait states
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 16'h1234;
    #1;
    chk("ld_stall_pre", 32'(pipe_stall), 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ld_req%0d", i), 32'(bus.mem_req), 1);
      chk($sformatf("ld_addr%0d", i), 32'(bus.mem_addr), 32'h1234);
      chk($sformatf("ld_stall%0d", i), 32'(pipe_stall), 1);
      chk($sformatf("ld_nodone%0d", i), 32'(pipe_done), 0);
      if (i == 3) begin bus.mem_ack = 1'b1; bus.mem_rdata = 12'hABC; end
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("ld_done", 32'(pipe_done), 1);
    chk("ld_rdata", 32'(rdata), 32'hABC);
    chk("ld_req_off", 32'(bus.mem_req), 0);
    chk("ld_stall_off", 32'(pipe_stall), 0);
    pipe_req = 1'b0;
    tick();
    chk("ld_done_1cyc", 32'(pipe_done), 0);

    // 3. tie after reset: pipe first, then cs push, next tie pipe again
    nreset = 1'b0; #2; nreset = 1'b1;
    tick();
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 16'h2000;
    cs_req = 1'b1; cs_we = 1'b1; cs_ptr = 8'h05; cs_wdata = 12'h123;
    tick();
    chk("tie1_addr", 32'(bus.mem_addr), 32'h2000);
    chk("tie1_we", 32'(bus.mem_we), 0);
    bus.mem_ack = 1'b1; bus.mem_rdata = 12'h055;
    tick();
    bus.mem_ack = 1'b0;
    chk("tie1_done", 32'({pipe_done, cs_done}), 32'b10);
    chk("tie1_rdata", 32'(rdata), 32'h055);
    pipe_req = 1'b0;
    tick();
    chk("tie_gap_req", 32'(bus.mem_req), 0);
    tick();
    chk("cs_req_on", 32'(bus.mem_req), 1);
    chk("cs_addr", 32'(bus.mem_addr), 32'hFF05);
    chk("cs_we", 32'(bus.mem_we), 1);
    chk("cs_wdata", 32'(bus.mem_wdata), 32'h123);
    bus.mem_ack = 1'b1; bus.mem_rdata = 12'h999;
    tick();
    bus.mem_ack = 1'b0;
    chk("cs_done", 32'({pipe_done, cs_done}), 32'b01);
    chk("push_keeps_rdata", 32'(rdata), 32'h055);
    cs_req = 1'b0;
    tick();
    pipe_req = 1'b1; pipe_addr = 16'h2002; cs_req = 1'b1; cs_we = 1'b0;
    tick();
    chk("tie2_addr", 32'(bus.mem_addr), 32'h2002);
    bus.mem_ack = 1'b1; bus.mem_rdata = 12'h7FF;
    tick();
    bus.mem_ack = 1'b0;
    chk("tie2_done", 32'(pipe_done), 1);
    pipe_req = 1'b0; cs_req = 1'b0;
    tick();

    // 4. timeout then normal access; bus_err sticky
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 16'h3000;
    tick();
    cnt = 0;
    while (bus.mem_req && cnt < 100) begin cnt++; tick(); end
    chk("to_req_cycles", 32'(cnt), 64);
    chk("to_done", 32'(pipe_done), 1);
    chk("to_bus_err", 32'(bus_err), 1);
    chk("to_rdata", 32'(rdata), 32'hFFF);
    pipe_req = 1'b0;
    tick();
    cs_req = 1'b1; cs_we = 1'b0; cs_ptr = 8'h10;
    tick();
    chk("post_to_addr", 32'(bus.mem_addr), 32'hFF10);
    bus.mem_ack = 1'b1; bus.mem_rdata = 12'h321;
    tick();
    bus.mem_ack = 1'b0;
    chk("post_to_done", 32'(cs_done), 1);
    chk("post_to_rdata", 32'(rdata), 32'h321);
    chk("err_sticky", 32'(bus_err), 1);
    cs_req = 1'b0;
    tick();

    // 5. back-to-back pops, W=0
    cs_req = 1'b1; cs_we = 1'b0; cs_ptr = 8'h20;
    ndone = 0; last_done = -1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      bus.mem_ack = 1'b0;
      if (pipe_done) chk("b2b_stray_pipe", 32'(pipe_done), 0);
      if (cs_done) begin
        exp_rd = 12'h100 + 12'(ndone);
        chk($sformatf("b2b_rdata%0d", ndone), 32'(rdata), 32'(exp_rd));
        if (last_done >= 0) chk("b2b_spacing", 32'(t - last_done), 3);
        last_done = t;
        ndone++;
        if (ndone == 3) cs_req = 1'b0;
      end
      if (bus.mem_req) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 12'h100 + 12'(ndone);
      end
    end
    chk("b2b_count", 32'(ndone), 3);
    chk("b2b_last_at", 32'(last_done), 8);
    tick();
    chk("b2b_idle", 32'({bus.mem_req, cs_done}), 0);

    // dropped request: access completes, done suppressed
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 16'h4000;
    tick();
    pipe_req = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 12'h246;
    tick();
    bus.mem_ack = 1'b0;
    chk("drop_no_done", 32'({pipe_done, cs_done}), 0);
    chk("drop_req_off", 32'(bus.mem_req), 0);
    tick();

    // 6. async reset mid-WAIT, late ack ignored
    pipe_req = 1'b1; pipe_addr = 16'h5000;
    tick();
    tick();
    chk("mid_wait_req", 32'(bus.mem_req), 1);
    #2 nreset = 1'b0;
    #1;
    chk("async_req_drop", 32'(bus.mem_req), 0);
    chk("async_err_clr", 32'(bus_err), 0);
    pipe_req = 1'b0;
    tick();
    nreset = 1'b1;
    bus.mem_ack = 1'b1; bus.mem_rdata = 12'h777;
    tick();
    bus.mem_ack = 1'b0;
    chk("late_ack_no_done", 32'({pipe_done, cs_done}), 0);
    chk("late_ack_rdata", 32'(rdata), 0);
    tick();
    chk("late_ack_idle", 32'({bus.mem_req, pipe_done}), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
